gate_sweep_ctrl: RTL and testbench

- Sequencer that exhaustively drives a 4-input combinational gate (a,b,c,d -> e) through all 16 input vectors.
- Waits a settle time per vector, samples e and compares it against an expected truth table.
- Reports error count, first failing vector and pass/fail.
- Sits between a lab control block (start/abort) and the gate under test, replacing free-running toggle stimulus with a checked, clocked sweep.

---
 rtl/gate_sweep_pkg.sv | 22 ++
 rtl/gate_sweep_ctrl_settle_timer.sv | 27 ++
 rtl/gate_sweep_ctrl.sv | 160 ++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared constants and types for the gate sweep controller.
package gate_sweep_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned ERR_W   = 5;

  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

  // Reference truth tables, bit i = expected e for {a,b,c,d} == i
  localparam logic [NUM_VEC-1:0] OR4_TT  = 16'hFFFE;
  localparam logic [NUM_VEC-1:0] AND4_TT = 16'h8000;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StFin    = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that holds at zero; flags when the settle time has elapsed.
module sweep_settle_timer
  import gate_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VEC_W-1:0] value,
  output logic             zero
);

  logic [VEC_W-1:0] cnt_q;

  // Load has priority over counting down; counting stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Checked exhaustive sweep of a 4-input gate: drives all 16 vectors, waits a
// settle time per vector, compares e against EXPECT_TT and reports the result.
// Optional macro GATE_SWEEP_TT_CAPTURE_EN adds obs_tt, the observed truth table.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0]   EXPECT_TT     = OR4_TT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
`ifdef GATE_SWEEP_TT_CAPTURE_EN
  output logic [NUM_VEC-1:0] obs_tt,
`endif
  output logic [VEC_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam logic [VEC_W-1:0] SETTLE_LOAD = VEC_W'(SETTLE_CYCLES - 1);

  sweep_state_e     state_q, state_d;
  logic [VEC_W-1:0] idx_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [VEC_W-1:0] ff_idx_q;
  logic             ff_vld_q;
  logic             pass_q;
  logic             cnt_zero;
  logic             sweep_start;
  logic             sample_en;
  logic             mismatch;
  logic             timer_load;

  // Abort only matters outside IDLE, but it also vetoes a start in IDLE
  assign sweep_start = (state_q == StIdle) && start && !abort;
  assign sample_en   = (state_q == StSample) && !abort;
  assign mismatch    = (e != EXPECT_TT[idx_q]);
  assign timer_load  = sweep_start || (sample_en && (idx_q != LAST_IDX));

  sweep_settle_timer u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .value (SETTLE_LOAD),
    .zero  (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort outranks every normal transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (sweep_start) state_d = StSettle;
      end
      StSettle: begin
        if (abort)         state_d = StIdle;
        else if (cnt_zero) state_d = StSample;
      end
      StSample: begin
        if (abort)                   state_d = StIdle;
        else if (idx_q == LAST_IDX)  state_d = StFin;
        else                         state_d = StSettle;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sweep datapath: vector index, error bookkeeping and final verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      err_cnt_q <= '0;
      ff_idx_q  <= '0;
      ff_vld_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else if (sweep_start) begin
      idx_q     <= '0;
      err_cnt_q <= '0;
      ff_idx_q  <= '0;
      ff_vld_q  <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      if (sample_en) begin
        // idx never wraps: the last vector leaves it at 15
        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
        if (mismatch) begin
          if (err_cnt_q != ERR_MAX) err_cnt_q <= err_cnt_q + 1'b1;
          if (!ff_vld_q) begin
            ff_idx_q <= idx_q;
            ff_vld_q <= 1'b1;
          end
        end
      end
      if ((state_q == StFin) && !abort) pass_q <= (err_cnt_q == '0);
    end
  end

`ifdef GATE_SWEEP_TT_CAPTURE_EN
  logic [NUM_VEC-1:0] obs_tt_q;

  // Observed truth table, one bit written per completed sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_tt_q <= '0;
    end else if (sweep_start) begin
      obs_tt_q <= '0;
    end else if (sample_en) begin
      obs_tt_q[idx_q] <= e;
    end
  end

  assign obs_tt = obs_tt_q;
`endif

  // Moore outputs; done is suppressed if abort lands on the FIN cycle
  always_comb begin
    {a, b, c, d} = '0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StSettle, StSample: begin
        {a, b, c, d} = idx_q;
        busy         = 1'b1;
      end
      StFin: begin
        busy = 1'b1;
        done = !abort;
      end
      default: ;
    endcase
  end

  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: three instances (default OR4, AND4
// expectation, SETTLE_CYCLES=1) selected one at a time through a small mux.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start, abort;
  int   sel;
  int   mode;  // stimulus on e for instance 0: 0 ideal OR4, 1 stuck-0, 2 stuck-1

  logic [2:0] start_w, abort_w, a_w, b_w, c_w, d_w, e_w, busy_w, done_w, pass_w, ffv_w;
  logic [4:0] err_w [3];
  logic [3:0] ffi_w [3];
`ifdef GATE_SWEEP_TT_CAPTURE_EN
  logic [15:0] obs_w [3];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_ctl
    assign start_w[k] = start && (sel == k);
    assign abort_w[k] = abort && (sel == k);
  end

  assign e_w[0] = (mode == 0) ? (a_w[0] | b_w[0] | c_w[0] | d_w[0]) : (mode == 2);
  assign e_w[1] = 1'b1;
  assign e_w[2] = a_w[2] | b_w[2] | c_w[2] | d_w[2];

  gate_sweep_ctrl u_dut_or (
    .clk (clk), .rst_n (rst_n), .start (start_w[0]), .abort (abort_w[0]),
    .a (a_w[0]), .b (b_w[0]), .c (c_w[0]), .d (d_w[0]), .e (e_w[0]),
    .busy (busy_w[0]), .done (done_w[0]), .pass (pass_w[0]), .err_cnt (err_w[0]),
`ifdef GATE_SWEEP_TT_CAPTURE_EN
    .obs_tt (obs_w[0]),
`endif
    .first_fail_idx (ffi_w[0]), .first_fail_vld (ffv_w[0])
  );

  gate_sweep_ctrl #(.EXPECT_TT (AND4_TT)) u_dut_and (
    .clk (clk), .rst_n (rst_n), .start (start_w[1]), .abort (abort_w[1]),
    .a (a_w[1]), .b (b_w[1]), .c (c_w[1]), .d (d_w[1]), .e (e_w[1]),
    .busy (busy_w[1]), .done (done_w[1]), .pass (pass_w[1]), .err_cnt (err_w[1]),
`ifdef GATE_SWEEP_TT_CAPTURE_EN
    .obs_tt (obs_w[1]),
`endif
    .first_fail_idx (ffi_w[1]), .first_fail_vld (ffv_w[1])
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES (1)) u_dut_s1 (
    .clk (clk), .rst_n (rst_n), .start (start_w[2]), .abort (abort_w[2]),
    .a (a_w[2]), .b (b_w[2]), .c (c_w[2]), .d (d_w[2]), .e (e_w[2]),
    .busy (busy_w[2]), .done (done_w[2]), .pass (pass_w[2]), .err_cnt (err_w[2]),
`ifdef GATE_SWEEP_TT_CAPTURE_EN
    .obs_tt (obs_w[2]),
`endif
    .first_fail_idx (ffi_w[2]), .first_fail_vld (ffv_w[2])
  );

  logic [3:0] o_vec;
  logic       o_busy, o_done, o_pass, o_ffv;
  logic [4:0] o_err;
  logic [3:0] o_ffi;

  assign o_vec  = {a_w[sel], b_w[sel], c_w[sel], d_w[sel]};
  assign o_busy = busy_w[sel];
  assign o_done = done_w[sel];
  assign o_pass = pass_w[sel];
  assign o_ffv  = ffv_w[sel];
  assign o_err  = err_w[sel];
  assign o_ffi  = ffi_w[sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Start a sweep on the selected instance; cycle numbering puts the start edge
  // at the end of cycle 0, so done_cyc is the cycle in which done is seen high.
  // poke > 0 re-asserts start for the edge numbered poke (must be ignored).
  task automatic run_sweep(input int per, input int poke,
                           output int done_cyc, output int walk_err);
    done_cyc = 0;
    walk_err = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (o_vec !== 4'd0) walk_err++;
    for (int k = 1; k <= 100 && done_cyc == 0; k++) begin
      if (k == poke) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (o_done) done_cyc = k + 1;
      else if (k < 16 * per && o_vec !== 4'(k / per)) walk_err++;
    end
  endtask

  task automatic post_check(input string pfx, input int done_cyc, input int walk_err,
                            input int done_exp, input logic pass_exp, input logic [4:0] err_exp,
                            input logic ffv_exp, input logic [3:0] ffi_exp);
    check({pfx, "_done_cycle"}, done_cyc, done_exp);
    check({pfx, "_walk"}, walk_err, 0);
    @(posedge clk); #1;
    check({pfx, "_done_pulse_1cyc"}, o_done, 1'b0);
    check({pfx, "_busy_idle"}, o_busy, 1'b0);
    check({pfx, "_pass"}, o_pass, pass_exp);
    check({pfx, "_err_cnt"}, o_err, err_exp);
    check({pfx, "_ff_vld"}, o_ffv, ffv_exp);
    if (ffv_exp) check({pfx, "_ff_idx"}, o_ffi, ffi_exp);
  endtask

  int dc, we, seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 0; mode = 0;
    #12;
    check("rst_busy", busy_w, 3'b000);
    check("rst_vec", {a_w, b_w, c_w, d_w}, 12'h000);
    check("rst_done_pass", {done_w, pass_w}, 6'b0);
    check("rst_err", o_err, 5'd0);
    check("rst_ff", {o_ffv, o_ffi}, 5'd0);
    @(negedge clk) rst_n = 1'b1;

    // 1: ideal OR4, start pulse mid-sweep must be ignored
    run_sweep(3, 10, dc, we);
    post_check("or4_ideal", dc, we, 49, 1'b1, 5'd0, 1'b0, 4'd0);

    // 2: e stuck at 0
    mode = 1;
    run_sweep(3, 0, dc, we);
    post_check("or4_stuck0", dc, we, 49, 1'b0, 5'd15, 1'b1, 4'd1);

    // 3: e stuck at 1 against AND4
    sel = 1;
    run_sweep(3, 0, dc, we);
    post_check("and4_stuck1", dc, we, 49, 1'b0, 5'd15, 1'b1, 4'd0);
`ifdef GATE_SWEEP_TT_CAPTURE_EN
    check("and4_obs_tt", obs_w[1], 16'hFFFF);
`endif

    // 4: abort sampled at edge 20 with e stuck at 0; sample of idx 6 is discarded
    sel = 0; mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", o_busy, 1'b0);
    check("abort_vec", o_vec, 4'd0);
    check("abort_err_partial", o_err, 5'd5);
    check("abort_ff", {o_ffv, o_ffi}, {1'b1, 4'd1});
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_done || o_pass) seen++;
    end
    check("abort_no_done_pass", seen, 0);
    mode = 0;
    run_sweep(3, 0, dc, we);
    post_check("after_abort", dc, we, 49, 1'b1, 5'd0, 1'b0, 4'd0);

    // 5: asynchronous reset between edges mid-SETTLE
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("pre_reset_err", o_err, 5'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", o_busy, 1'b0);
    check("async_rst_vec", o_vec, 4'd0);
    check("async_rst_err_ff", {o_err, o_ffv, o_ffi}, 10'd0);
    @(negedge clk) rst_n = 1'b1;
    // start and abort together in IDLE: no sweep
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
    check("start_abort_idle", o_busy, 1'b0);
    @(posedge clk); #1 check("start_abort_idle2", o_busy, 1'b0);

    // start held high: new sweep starts on the first IDLE cycle after FIN
    mode = 0;
    @(negedge clk) start = 1'b1;
    dc = 0;
    for (int k = 0; k < 100 && dc == 0; k++) begin
      @(posedge clk); #1;
      if (o_done) dc = 1;
    end
    check("held_done_seen", dc, 1);
    @(posedge clk); #1;
    check("held_idle_gap", {o_busy, o_pass}, 2'b01);
    @(posedge clk); #1;
    check("held_restart", {o_busy, o_vec}, 5'b1_0000);
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;

    // 6: SETTLE_CYCLES=1
    sel = 2;
    run_sweep(2, 0, dc, we);
    post_check("settle1", dc, we, 33, 1'b1, 5'd0, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
